// File: rtl/dm_unit.sv
// Data memory stage: byte/halfword/word stores, sign/zero-extended loads,
// misalignment detection with a sticky first-fault address register.
module dm_unit #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] dm_write,
  input  logic        MemWrite,
  input  logic        MemRead,
  input  logic [1:0]  DMSize,
  input  logic        LoadSign,
  input  logic        err_clr,
  output logic [31:0] dm_out,
  output logic        addr_err,
  output logic        err_valid,
  output logic [31:0] bad_addr
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  logic [31:0]       mem_q [Depth];
  logic [ADDR_W-1:0] widx;
  logic              misaligned;
  logic              access_ok;
  logic              wr_en;
  logic [31:0]       wr_mask;
  logic [31:0]       wr_data;
  logic [31:0]       rd_word;
  logic [31:0]       rd_shift;
  logic              err_valid_q, err_valid_d;
  logic [31:0]       bad_addr_q, bad_addr_d;

  // Upper address bits are dropped so accesses wrap around the array.
  assign widx = addr[ADDR_W+1:2];

  always_comb begin
    misaligned = 1'b0;
    case (DMSize)
      2'b00:   misaligned = (addr[1:0] != 2'b00);
      2'b01:   misaligned = addr[0];
      default: misaligned = 1'b0;
    endcase
  end

  assign access_ok = ~misaligned & (DMSize != 2'b11);
  assign addr_err  = (MemRead | MemWrite) & misaligned;
  assign wr_en     = MemWrite & access_ok;

  // Sub-word data is replicated across lanes; the mask picks the live lane.
  always_comb begin
    wr_mask = '0;
    wr_data = '0;
    case (DMSize)
      2'b00: begin
        wr_mask = 32'hFFFF_FFFF;
        wr_data = dm_write;
      end
      2'b01: begin
        wr_mask = addr[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
        wr_data = {2{dm_write[15:0]}};
      end
      2'b10: begin
        wr_mask = 32'h0000_00FF << {addr[1:0], 3'b000};
        wr_data = {4{dm_write[7:0]}};
      end
      default: begin
        wr_mask = '0;
        wr_data = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en) begin
      mem_q[widx] <= (mem_q[widx] & ~wr_mask) | (wr_data & wr_mask);
    end
  end

  assign rd_word  = mem_q[widx];
  assign rd_shift = rd_word >> {addr[1:0], 3'b000};

  always_comb begin
    dm_out = '0;
    if (MemRead && access_ok) begin
      case (DMSize)
        2'b00:   dm_out = rd_word;
        2'b01:   dm_out = {{16{LoadSign & rd_shift[15]}}, rd_shift[15:0]};
        2'b10:   dm_out = {{24{LoadSign & rd_shift[7]}}, rd_shift[7:0]};
        default: dm_out = '0;
      endcase
    end
  end

  // A new fault always wins over a same-cycle clear.
  always_comb begin
    err_valid_d = err_valid_q;
    bad_addr_d  = bad_addr_q;
    if (addr_err && (!err_valid_q || err_clr)) begin
      err_valid_d = 1'b1;
      bad_addr_d  = addr;
    end else if (err_clr) begin
      err_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_valid_q <= 1'b0;
      bad_addr_q  <= '0;
    end else begin
      err_valid_q <= err_valid_d;
      bad_addr_q  <= bad_addr_d;
    end
  end

  assign err_valid = err_valid_q;
  assign bad_addr  = bad_addr_q;

endmodule

// File: tb/tb_dm_unit.sv
// Self-checking bench for dm_unit: directed scenarios plus random accesses
// checked against a byte-array reference model.
module tb_dm_unit;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned NBYTES = 4 * (2 ** ADDR_W);

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr;
  logic [31:0] dm_write;
  logic        MemWrite;
  logic        MemRead;
  logic [1:0]  DMSize;
  logic        LoadSign;
  logic        err_clr;
  logic [31:0] dm_out;
  logic        addr_err;
  logic        err_valid;
  logic [31:0] bad_addr;

  int total = 0;
  int bad   = 0;

  byte unsigned ref_mem [NBYTES];
  logic         ref_ev;
  logic [31:0]  ref_ba;
  logic [31:0]  obs_out;

  dm_unit #(.ADDR_W(ADDR_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .addr     (addr),
    .dm_write (dm_write),
    .MemWrite (MemWrite),
    .MemRead  (MemRead),
    .DMSize   (DMSize),
    .LoadSign (LoadSign),
    .err_clr  (err_clr),
    .dm_out   (dm_out),
    .addr_err (addr_err),
    .err_valid(err_valid),
    .bad_addr (bad_addr)
  );

  always #5 clk = ~clk;

  function automatic int nbytes_of(input logic [1:0] size);
    if (size == 2'd0) return 4;
    if (size == 2'd1) return 2;
    if (size == 2'd2) return 1;
    return 0;
  endfunction

  function automatic logic is_mis(input logic [31:0] a, input logic [1:0] size);
    int n = nbytes_of(size);
    return (n > 1) && ((a % n) != 0);
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] size,
                                             input logic sgn);
    int     n = nbytes_of(size);
    longint v = 0;
    int     base = int'(a % NBYTES);
    if (n == 0 || is_mis(a, size)) return 32'h0;
    for (int k = 0; k < n; k++) v = v + (longint'(ref_mem[base + k]) << (8 * k));
    if (sgn && n < 4 && ((v >> (8 * n - 1)) & 1) == 1) v = v + (64'h1_0000_0000 - (64'h1 << (8 * n)));
    return v[31:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // One access cycle: check combinational outputs, clock, update model, check error regs.
  task automatic acc(input string tag, input logic [31:0] a, input logic [31:0] d,
                     input logic we, input logic re, input logic [1:0] size,
                     input logic sgn, input logic clr);
    logic        mis;
    logic        aerr;
    int          n;
    int          base;
    addr = a; dm_write = d; MemWrite = we; MemRead = re; DMSize = size;
    LoadSign = sgn; err_clr = clr;
    #1;
    mis  = is_mis(a, size);
    aerr = (we | re) & mis;
    obs_out = dm_out;
    chk({tag, ".dm_out"}, dm_out, re ? model_load(a, size, sgn) : 32'h0);
    chk({tag, ".addr_err"}, {31'b0, addr_err}, {31'b0, aerr});
    @(posedge clk);
    #1;
    n = nbytes_of(size);
    base = int'(a % NBYTES);
    if (we && !mis) for (int k = 0; k < n; k++) ref_mem[base + k] = 8'(d >> (8 * k));
    if (aerr && (!ref_ev || clr)) begin
      ref_ev = 1'b1;
      ref_ba = a;
    end else if (clr) begin
      ref_ev = 1'b0;
    end
    chk({tag, ".err_valid"}, {31'b0, err_valid}, {31'b0, ref_ev});
    chk({tag, ".bad_addr"}, bad_addr, ref_ba);
    MemWrite = 1'b0; MemRead = 1'b0; err_clr = 1'b0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NBYTES; i++) ref_mem[i] = 8'h00;
    ref_ev = 1'b0;
    ref_ba = 32'h0;
  endtask

  initial begin
    reset = 1'b1; addr = '0; dm_write = '0; MemWrite = 1'b0; MemRead = 1'b0;
    DMSize = 2'b00; LoadSign = 1'b0; err_clr = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    acc("rst_load", 32'h0, 32'h0, 0, 1, 2'b00, 0, 0);
    chk("rst_word0", obs_out, 32'h0000_0000);
    chk("rst_ev", {31'b0, err_valid}, 32'h0);
    chk("rst_ba", bad_addr, 32'h0);

    acc("st_w10", 32'h10, 32'h1122_3344, 1, 0, 2'b00, 0, 0);
    acc("st_b11", 32'h11, 32'h0000_00AA, 1, 0, 2'b10, 0, 0);
    acc("ld_w10", 32'h10, 32'h0, 0, 1, 2'b00, 0, 0);
    chk("merge_word", obs_out, 32'h1122_AA44);

    acc("st_h22", 32'h22, 32'h0000_8001, 1, 0, 2'b01, 0, 0);
    acc("ld_h22s", 32'h22, 32'h0, 0, 1, 2'b01, 1, 0);
    chk("half_sext", obs_out, 32'hFFFF_8001);
    acc("ld_h22z", 32'h22, 32'h0, 0, 1, 2'b01, 0, 0);
    chk("half_zext", obs_out, 32'h0000_8001);
    acc("ld_b23s", 32'h23, 32'h0, 0, 1, 2'b10, 1, 0);
    chk("byte_sext", obs_out, 32'hFFFF_FF80);

    acc("st_mis41", 32'h41, 32'hDEAD_BEEF, 1, 0, 2'b00, 0, 0);
    chk("mis_ev", {31'b0, err_valid}, 32'h1);
    chk("mis_ba", bad_addr, 32'h41);
    acc("ld_w40", 32'h40, 32'h0, 0, 1, 2'b00, 0, 0);
    chk("mis_nowrite", obs_out, 32'h0);
    acc("ld_mis43", 32'h43, 32'h0, 0, 1, 2'b01, 0, 0);
    chk("first_fault", bad_addr, 32'h41);
    chk("mis_ld_zero", obs_out, 32'h0);
    acc("clr", 32'h0, 32'h0, 0, 0, 2'b00, 0, 1);
    chk("clr_ev", {31'b0, err_valid}, 32'h0);
    chk("clr_ba_kept", bad_addr, 32'h41);

    acc("ld_w40b", 32'h40, 32'h0, 0, 1, 2'b00, 0, 0);
    acc("clr_err05", 32'h05, 32'h0, 0, 1, 2'b00, 0, 1);
    chk("clr_err_ev", {31'b0, err_valid}, 32'h1);
    chk("clr_err_ba", bad_addr, 32'h05);

    acc("st_wrap", 32'h4 + NBYTES, 32'hCAFE_F00D, 1, 0, 2'b00, 0, 0);
    acc("ld_wrap", 32'h4, 32'h0, 0, 1, 2'b00, 0, 0);
    chk("wrap", obs_out, 32'hCAFE_F00D);
    acc("rw_same", 32'h4, 32'h1234_5678, 1, 1, 2'b00, 0, 0);
    chk("rw_old", obs_out, 32'hCAFE_F00D);
    acc("rw_next", 32'h4, 32'h0, 0, 1, 2'b00, 0, 0);
    chk("rw_new", obs_out, 32'h1234_5678);
    acc("none11", 32'h4, 32'hFFFF_FFFF, 1, 1, 2'b11, 1, 0);
    chk("none_out", obs_out, 32'h0);

    for (int i = 0; i < 400; i++) begin
      logic [31:0] ra;
      ra = {$urandom_range(0, 3) == 0 ? 32'($urandom) : 32'h0} & 32'hFFFF_F000;
      ra = ra | 32'($urandom_range(0, 63));
      acc("rand", ra, $urandom, 1'($urandom), 1'($urandom), 2'($urandom),
          1'($urandom), $urandom_range(0, 9) == 0);
    end

    // Reset mid-sequence with a store pending across the edge.
    acc("pre_rst", 32'h13, 32'h0, 0, 1, 2'b00, 0, 0);
    addr = 32'h8; dm_write = 32'h5555_AAAA; MemWrite = 1'b1; DMSize = 2'b00;
    #2 reset = 1'b1;
    @(posedge clk);
    #2 reset = 1'b0;
    MemWrite = 1'b0;
    model_reset();
    chk("mid_rst_ev", {31'b0, err_valid}, 32'h0);
    chk("mid_rst_ba", bad_addr, 32'h0);
    for (int w = 0; w < 64; w += 4) begin
      acc("post_rst", 32'(w), 32'h0, 0, 1, 2'b00, 0, 0);
      chk("post_rst_zero", obs_out, 32'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
